br_resolve_unit: RTL and testbench
==================================

Name: br_resolve_unit

Overview:
- EX-stage counterpart to the fetch-stage branch predictor.
- Fetch logs each predicted conditional branch (pc, prediction, alternate pc) into an in-order queue.
- EX resolves the oldest entry with the actual outcome. On mismatch this block issues a one-cycle flush plus redirect pc, and drops all younger wrong-path entries.
- Every resolution also produces a predictor-update pulse and feeds saturating branch/miss statistics counters.

Parameters:
DEPTH, 4, in-flight branch queue entries (power of 2, >=2)
PC_W, 32, pc width
CNT_W, 16, statistics counter width

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_stall  in  1  pipeline stall; blocks push only, not resolve
i_push  in  1  fetch issues a predicted conditional branch
i_push_pc  in  PC_W  pc of the branch
i_push_pred  in  1  predicted direction, 1 = taken
i_push_alt  in  PC_W  pc of the path not chosen (pc+4 if predicted taken, pc+imm if predicted not-taken)
i_res_valid  in  1  EX resolves the oldest outstanding branch
i_res_taken  in  1  actual direction
o_full  out  1  queue holds DEPTH entries
o_empty  out  1  queue holds 0 entries
o_flush  out  1  mispredict pulse, registered
o_redirect_pc  out  PC_W  correct fetch pc, valid while o_flush=1
o_upd_valid  out  1  predictor update pulse, registered
o_upd_pc  out  PC_W  pc of the resolved branch
o_upd_taken  out  1  actual direction of the resolved branch
o_br_cnt  out  CNT_W  resolved branches, saturating
o_miss_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset (i_rst_n=0 at a rising edge):
  - Queue empty: rd_ptr = wr_ptr = 0, count = 0.
  - o_empty=1, o_full=0.
  - o_flush = o_upd_valid = 0; o_redirect_pc = o_upd_pc = 0; o_upd_taken = 0.
  - Both counters = 0.
  - Reset mid-operation discards all entries with no flush pulse.
- Storage:
  - Circular buffer of {pc, pred, alt}.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Separate count register, range 0..DEPTH.
  - o_full = (count==DEPTH); o_empty = (count==0); both combinational from count.
- Push accept: push_ok = i_push & ~i_stall & (~o_full | res_ok) & ~miss.
  - Push into a full queue is allowed only when a resolve pops in the same cycle.
  - A rejected push is lost. Fetch must hold off on o_full.
- Resolve accept: res_ok = i_res_valid & ~o_empty.
  - Resolve while empty is ignored: no pop, no pulses, no count change.
- Mispredict: miss = res_ok & (i_res_taken != head.pred), all combinational on the current head.
- At the rising edge, in priority order:
  1. miss:
     - Clear the queue: rd_ptr = wr_ptr, count = 0.
     - Any same-cycle push is dropped as wrong-path.
     - Next cycle: o_flush=1, o_redirect_pc = head.alt.
  2. res_ok without miss:
     - Pop the head.
     - If push_ok in the same cycle: write at wr_ptr, count unchanged.
  3. push_ok only: write at wr_ptr, count+1.
- Predictor update pulse:
  - Any res_ok gives, next cycle: o_upd_valid=1, o_upd_pc = head.pc, o_upd_taken = i_res_taken.
  - Pulse-type outputs are high for exactly one cycle per event. Back-to-back resolves give back-to-back pulses.
- Statistics:
  - o_br_cnt += 1 on res_ok; o_miss_cnt += 1 on miss.
  - Both update at the same edge as the pop.
  - Both saturate at 2^CNT_W-1 with no wrap.
- Timing: total latency resolve -> flush/update = 1 cycle; all outputs except o_full/o_empty are registered.
- Stall interaction: i_stall does not gate resolution or flush. The flush overrides the stall downstream.
- No combinational path from i_res_* to o_flush.

Test Plan:
- Reset then idle -> o_empty=1, o_full=0, all pulses 0, counters 0; resolve with i_res_valid=1 on the empty queue -> no pulse, o_br_cnt stays 0.
- Push pc=0x10 pred=1 alt=0x14; resolve taken=1 -> next cycle o_upd_valid=1, o_upd_pc=0x10, o_upd_taken=1, o_flush=0; o_br_cnt=1, o_empty=1.
- Push pc=0x20 pred=0 alt=0x40, then push pc=0x44; resolve taken=1 -> o_flush=1 for one cycle, o_redirect_pc=0x40; queue empty (pc=0x44 dropped); o_miss_cnt=1.
- Fill DEPTH=4 pushes -> o_full=1; a 5th push alone is rejected (count stays 4); a 5th push together with a correct resolve is accepted, count stays 4, order preserved across pointer wrap.
- Push asserted with i_stall=1 -> not enqueued; resolve with i_stall=1 still pops and pulses o_upd_valid.
- Mispredict resolve and push in the same cycle -> push dropped, o_empty=1 after the edge; reset asserted with 3 entries queued -> o_empty=1, no o_flush pulse.

Source files
------------

// File: rtl/br_resolve_unit.sv
// rtl/br_resolve_unit.sv - EX-stage branch resolution queue with flush, predictor update and statistics
//
// Fetch pushes each predicted conditional branch {pc, pred, alt} into an
// in-order circular queue. EX resolves the oldest entry with the actual
// direction. A wrong prediction clears the whole queue, because every younger
// entry is on the wrong path, and issues a one-cycle flush with the correct
// fetch pc.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_stall               blocks push only; resolve still proceeds
//   i_push, i_push_pc, i_push_pred, i_push_alt
//                         new predicted branch from fetch
//   i_res_valid, i_res_taken
//                         resolution of the oldest branch
//   o_full, o_empty       queue occupancy flags (combinational from count)
//   o_flush, o_redirect_pc
//                         registered mispredict pulse and correct pc
//   o_upd_valid, o_upd_pc, o_upd_taken
//                         registered predictor-update pulse
//   o_br_cnt, o_miss_cnt  saturating resolved-branch / mispredict counters
module br_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_push,
  input  logic [PC_W-1:0]  i_push_pc,
  input  logic             i_push_pred,
  input  logic [PC_W-1:0]  i_push_alt,
  input  logic             i_res_valid,
  input  logic             i_res_taken,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_flush,
  output logic [PC_W-1:0]  o_redirect_pc,
  output logic             o_upd_valid,
  output logic [PC_W-1:0]  o_upd_pc,
  output logic             o_upd_taken,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_miss_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};

  logic [PC_W-1:0]  r_pc_q   [DEPTH];
  logic             r_pred_q [DEPTH];
  logic [PC_W-1:0]  r_alt_q  [DEPTH];

  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             r_flush;
  logic [PC_W-1:0]  r_redirect_pc;
  logic             r_upd_valid;
  logic [PC_W-1:0]  r_upd_pc;
  logic             r_upd_taken;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic             w_full;
  logic             w_empty;
  logic [PC_W-1:0]  w_head_pc;
  logic             w_head_pred;
  logic [PC_W-1:0]  w_head_alt;
  logic             w_res_ok;
  logic             w_miss;
  logic             w_push_ok;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_head_pc   = r_pc_q[r_rd_ptr];
  assign w_head_pred = r_pred_q[r_rd_ptr];
  assign w_head_alt  = r_alt_q[r_rd_ptr];

  assign w_res_ok  = i_res_valid & ~w_empty;
  assign w_miss    = w_res_ok & (i_res_taken != w_head_pred);
  // A full queue can still accept a push when the head pops this cycle.
  // On a mispredict the pushed branch is younger than the bad one, so it is
  // wrong-path and dropped.
  assign w_push_ok = i_push & ~i_stall & (~w_full | w_res_ok) & ~w_miss;

  always_ff @(posedge i_clk) begin
    if (i_rst_n && w_push_ok) begin
      r_pc_q[r_wr_ptr]   <= i_push_pc;
      r_pred_q[r_wr_ptr] <= i_push_pred;
      r_alt_q[r_wr_ptr]  <= i_push_alt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_flush       <= 1'b0;
      r_redirect_pc <= '0;
      r_upd_valid   <= 1'b0;
      r_upd_pc      <= '0;
      r_upd_taken   <= 1'b0;
      r_br_cnt      <= '0;
      r_miss_cnt    <= '0;
    end else begin
      if (w_miss) begin
        // Discard everything by catching the read pointer up to the writer.
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_res_ok) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        if (w_push_ok) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_push_ok && !w_res_ok) begin
          r_count <= r_count + CNT_ONE;
        end else if (w_res_ok && !w_push_ok) begin
          r_count <= r_count - CNT_ONE;
        end
      end

      r_flush     <= w_miss;
      r_upd_valid <= w_res_ok;
      if (w_miss) begin
        r_redirect_pc <= w_head_alt;
      end
      if (w_res_ok) begin
        r_upd_pc    <= w_head_pc;
        r_upd_taken <= i_res_taken;
      end

      if (w_res_ok && (r_br_cnt != STAT_MAX)) begin
        r_br_cnt <= r_br_cnt + 1'b1;
      end
      if (w_miss && (r_miss_cnt != STAT_MAX)) begin
        r_miss_cnt <= r_miss_cnt + 1'b1;
      end
    end
  end

  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_flush       = r_flush;
  assign o_redirect_pc = r_redirect_pc;
  assign o_upd_valid   = r_upd_valid;
  assign o_upd_pc      = r_upd_pc;
  assign o_upd_taken   = r_upd_taken;
  assign o_br_cnt      = r_br_cnt;
  assign o_miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_br_resolve_unit.sv
// tb/tb_br_resolve_unit.sv - scoreboard bench for br_resolve_unit
module tb_br_resolve_unit;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = 4;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_stall;
  logic             i_push;
  logic [PC_W-1:0]  i_push_pc;
  logic             i_push_pred;
  logic [PC_W-1:0]  i_push_alt;
  logic             i_res_valid;
  logic             i_res_taken;
  logic             o_full;
  logic             o_empty;
  logic             o_flush;
  logic [PC_W-1:0]  o_redirect_pc;
  logic             o_upd_valid;
  logic [PC_W-1:0]  o_upd_pc;
  logic             o_upd_taken;
  logic [CNT_W-1:0] o_br_cnt;
  logic [CNT_W-1:0] o_miss_cnt;

  br_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stall      (i_stall),
    .i_push       (i_push),
    .i_push_pc    (i_push_pc),
    .i_push_pred  (i_push_pred),
    .i_push_alt   (i_push_alt),
    .i_res_valid  (i_res_valid),
    .i_res_taken  (i_res_taken),
    .o_full       (o_full),
    .o_empty      (o_empty),
    .o_flush      (o_flush),
    .o_redirect_pc(o_redirect_pc),
    .o_upd_valid  (o_upd_valid),
    .o_upd_pc     (o_upd_pc),
    .o_upd_taken  (o_upd_taken),
    .o_br_cnt     (o_br_cnt),
    .o_miss_cnt   (o_miss_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        flush;
    logic [31:0] redir;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every update pulse must match the oldest expected resolution.
  always @(negedge i_clk) begin
    if (o_upd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_upd_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("upd_pc", o_upd_pc, e.pc);
        chk("upd_taken", {31'd0, o_upd_taken}, {31'd0, e.taken});
        chk("flush", {31'd0, o_flush}, {31'd0, e.flush});
        if (e.flush) chk("redirect_pc", o_redirect_pc, e.redir);
      end
    end else if (o_flush !== 1'b0) begin
      chk("flush_without_upd", {31'd0, o_flush}, 32'd0);
    end
  end

  task automatic expect_res(input logic [31:0] pc, input logic taken,
                            input logic flush, input logic [31:0] redir);
    exp_t e;
    e.pc = pc; e.taken = taken; e.flush = flush; e.redir = redir;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; inputs are released 1 time unit after the edge.
  task automatic cyc(input logic push, input logic [31:0] pc, input logic pred,
                     input logic [31:0] alt, input logic res, input logic taken,
                     input logic stall);
    i_push = push; i_push_pc = pc; i_push_pred = pred; i_push_alt = alt;
    i_res_valid = res; i_res_taken = taken; i_stall = stall;
    @(posedge i_clk); #1;
    i_push = 1'b0; i_res_valid = 1'b0; i_stall = 1'b0;
    if (res) begin
      @(negedge i_clk); #1;
      chk("pulse_latency", exp_q.size(), 32'd0);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic pred, input logic [31:0] alt);
    cyc(1'b1, pc, pred, alt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic taken);
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, taken, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_stall = 1'b0; i_push = 1'b0; i_push_pc = '0;
    i_push_pred = 1'b0; i_push_alt = '0; i_res_valid = 1'b0; i_res_taken = 1'b0;
    idle(); idle();
    i_rst_n = 1'b1;
    idle();

    // Reset state
    chk("rst_empty", {31'd0, o_empty}, 32'd1);
    chk("rst_full", {31'd0, o_full}, 32'd0);
    chk("rst_flush", {31'd0, o_flush}, 32'd0);
    chk("rst_upd_valid", {31'd0, o_upd_valid}, 32'd0);
    chk("rst_redirect", o_redirect_pc, 32'd0);
    chk("rst_upd_pc", o_upd_pc, 32'd0);
    chk("rst_br_cnt", {28'd0, o_br_cnt}, 32'd0);
    chk("rst_miss_cnt", {28'd0, o_miss_cnt}, 32'd0);

    // Resolve on empty queue is ignored
    resolve(1'b1);
    chk("empty_res_br_cnt", {28'd0, o_br_cnt}, 32'd0);

    // Correct prediction
    push(32'h10, 1'b1, 32'h14);
    chk("one_entry_empty", {31'd0, o_empty}, 32'd0);
    expect_res(32'h10, 1'b1, 1'b0, 32'h0);
    resolve(1'b1);
    chk("correct_br_cnt", {28'd0, o_br_cnt}, 32'd1);
    chk("correct_empty", {31'd0, o_empty}, 32'd1);

    // Mispredict drops younger entry
    push(32'h20, 1'b0, 32'h40);
    push(32'h44, 1'b1, 32'h48);
    expect_res(32'h20, 1'b1, 1'b1, 32'h40);
    resolve(1'b1);
    chk("miss_empty", {31'd0, o_empty}, 32'd1);
    chk("miss_cnt1", {28'd0, o_miss_cnt}, 32'd1);
    chk("miss_br_cnt", {28'd0, o_br_cnt}, 32'd2);
    idle();
    chk("flush_one_cycle", {31'd0, o_flush}, 32'd0);

    // Fill to full across pointer wrap
    for (int k = 0; k < DEPTH; k++) push(32'h100 + k, 1'b1, 32'h104 + k);
    chk("fill_full", {31'd0, o_full}, 32'd1);
    push(32'h104, 1'b1, 32'h108);               // rejected
    chk("reject_full", {31'd0, o_full}, 32'd1);
    expect_res(32'h100, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 32'h105, 1'b1, 32'h109, 1'b1, 1'b1, 1'b0);
    chk("push_pop_full", {31'd0, o_full}, 32'd1);
    expect_res(32'h101, 1'b1, 1'b0, 32'h0); resolve(1'b1);
    expect_res(32'h102, 1'b1, 1'b0, 32'h0); resolve(1'b1);
    expect_res(32'h103, 1'b1, 1'b0, 32'h0); resolve(1'b1);
    expect_res(32'h105, 1'b1, 1'b0, 32'h0); resolve(1'b1);
    chk("drain_empty", {31'd0, o_empty}, 32'd1);
    chk("drain_br_cnt", {28'd0, o_br_cnt}, 32'd7);

    // Stall blocks push but not resolve
    cyc(1'b1, 32'h200, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1);
    chk("stall_no_push", {31'd0, o_empty}, 32'd1);
    push(32'h210, 1'b0, 32'h300);
    expect_res(32'h210, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("stall_res_empty", {31'd0, o_empty}, 32'd1);
    chk("stall_br_cnt", {28'd0, o_br_cnt}, 32'd8);

    // Mispredict with same-cycle push
    push(32'h400, 1'b1, 32'h404);
    expect_res(32'h400, 1'b0, 1'b1, 32'h404);
    cyc(1'b1, 32'h500, 1'b1, 32'h504, 1'b1, 1'b0, 1'b0);
    chk("miss_push_dropped", {31'd0, o_empty}, 32'd1);
    chk("miss_cnt2", {28'd0, o_miss_cnt}, 32'd2);

    // Reset with entries queued
    push(32'h600, 1'b1, 32'h604);
    push(32'h610, 1'b0, 32'h620);
    push(32'h630, 1'b1, 32'h634);
    chk("three_queued", {31'd0, o_empty}, 32'd0);
    i_rst_n = 1'b0;
    idle();
    i_rst_n = 1'b1;
    chk("midrst_empty", {31'd0, o_empty}, 32'd1);
    chk("midrst_flush", {31'd0, o_flush}, 32'd0);
    chk("midrst_br_cnt", {28'd0, o_br_cnt}, 32'd0);
    idle();

    // Saturation: 17 mispredicts with a 4-bit counter
    for (int k = 0; k < 17; k++) begin
      push(32'h1000 + 8 * k, 1'b0, 32'h2000 + 8 * k);
      expect_res(32'h1000 + 8 * k, 1'b1, 1'b1, 32'h2000 + 8 * k);
      resolve(1'b1);
    end
    chk("sat_br_cnt", {28'd0, o_br_cnt}, 32'd15);
    chk("sat_miss_cnt", {28'd0, o_miss_cnt}, 32'd15);

    idle(); idle();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
